serial_addsub: RTL

- Bit-serial adder/subtractor: accepts two WIDTH-bit operands, processes one bit per clock LSB-first through a single 1-bit full-adder cell, and returns the WIDTH-bit result with carry and signed overflow.
- Consumes the team's 1-bit full-adder cell and sequences it over a word.
- Small-area arithmetic for control paths where latency is acceptable.

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/fa_bit_cell.sv | 11 +
 rtl/serial_addsub.sv | 93 +++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared width default and state encoding for the bit-serial adder/subtractor
package serial_addsub_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/fa_bit_cell.sv
// fa_bit_cell: combinational 1-bit full adder (a, b, cin -> s, cout)
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial add/subtract through one full-adder cell, with carry and signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cy_q, cy_d, ov_q, ov_d;
  logic fa_s, fa_c, last;
  fa_bit_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .cout(fa_c)
  );
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    res_d = res_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    cy_d = cy_q;
    ov_d = ov_q;
    if (state_q == SHIFT) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      c_d = fa_c;
      res_d = {fa_s, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        sum_d = {fa_s, res_q[WIDTH-1:1]};
        cy_d = fa_c;
        ov_d = (a_q[0] == b_q[0]) && (fa_s != a_q[0]);
        state_d = DONE;
      end
    end else if (start) begin
      a_d = a_in;
      b_d = b_in ^ {WIDTH{sub}};
      c_d = sub;
      cnt_d = '0;
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      cy_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cy_q <= cy_d;
      ov_q <= ov_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign sum_out = sum_q;
  assign carry_out = cy_q;
  assign overflow = ov_q;
endmodule
